// File: rtl/sort_stream.sv
// sort_stream: collects a frame of up to DEPTH elements, sorts it with an
// odd-even transposition network (one phase per cycle), then streams the
// sorted elements out with valid/ready handshaking.
// Optional feature macro: SORT_STREAM_BYPASS_EN adds a 'bypass' input that,
// when set on the first beat of a frame, skips sorting and replays arrival order.
module sort_stream #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
`ifdef SORT_STREAM_BYPASS_EN
    input  logic             bypass,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             in_dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             frame_err,
    output logic [15:0]      frames_done
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0] LAST_SLOT = IW'(DEPTH - 1);

    typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] mem    [DEPTH];
    logic [WIDTH-1:0] sorted [DEPTH];
    logic [IW-1:0]    cnt;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    last_idx;
    logic [IW-1:0]    sort_cnt;
    logic             dir;
    logic             accept;
    logic             closing;
    logic             eff_dir;
    logic             eff_byp;

    // The first beat of a frame carries the direction (and bypass) directly;
    // later beats use the values latched from that first beat.
    assign eff_dir = (cnt == '0) ? in_dir : dir;
    assign accept  = (state == LOAD) && in_valid;
    assign closing = accept && (in_last || (cnt == LAST_SLOT));

`ifdef SORT_STREAM_BYPASS_EN
    logic byp;
    assign eff_byp = (cnt == '0) ? bypass : byp;
`else
    assign eff_byp = 1'b0;
`endif

    // Output data is forced to zero outside DRAIN so storage is never visible.
    assign out_data = (state == DRAIN) ? mem[idx] : '0;
    assign out_last = (state == DRAIN) && (idx == last_idx);

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (closing) begin
                    state_next = eff_byp ? DRAIN : SORT;
                end
            end
            SORT: begin
                if (sort_cnt == LAST_SLOT) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && (idx == last_idx)) begin
                    state_next = LOAD;
                end
            end
            default: state_next = LOAD;
        endcase
    end

    // One odd-even transposition phase; even pairs on even sort cycles.
    // Strict comparison keeps equal elements in place, so real values equal
    // to the sentinel stay ahead of the padding.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            sorted[i] = mem[i];
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (i[0] == sort_cnt[0]) begin
                if (dir ? (mem[i] > mem[i+1]) : (mem[i] < mem[i+1])) begin
                    sorted[i]   = mem[i+1];
                    sorted[i+1] = mem[i];
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Frame bookkeeping: load counter, latched size/direction, drain index, status.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            idx         <= '0;
            last_idx    <= '0;
            sort_cnt    <= '0;
            dir         <= 1'b0;
            frame_err   <= 1'b0;
            frames_done <= '0;
`ifdef SORT_STREAM_BYPASS_EN
            byp         <= 1'b0;
`endif
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        if (cnt == '0) begin
                            dir <= in_dir;
`ifdef SORT_STREAM_BYPASS_EN
                            byp <= bypass;
`endif
                        end
                        if (closing) begin
                            cnt      <= '0;
                            last_idx <= cnt;
                            sort_cnt <= '0;
                            idx      <= '0;
                            if (!in_last) begin
                                frame_err <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                SORT: begin
                    sort_cnt <= sort_cnt + 1'b1;
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (idx == last_idx) begin
                            idx         <= '0;
                            frames_done <= frames_done + 16'd1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Element storage: load beats, pad unused slots with the sentinel when
    // the frame closes, and apply one sort phase per SORT cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (accept) begin
                mem[cnt] <= in_data;
                if (closing) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (i > int'(cnt)) begin
                            mem[i] <= eff_dir ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
                        end
                    end
                end
            end else if (state == SORT) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem[i] <= sorted[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_sort_stream.sv
// tb_sort_stream: randomized self-checking bench for sort_stream, compared
// against a reference that simply sorts each frame's values.
module tb_sort_stream;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             in_dir;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             frame_err;
    logic [15:0]      frames_done;

    int               tests_run    = 0;
    int               tests_failed = 0;
    int               cyc          = 0;
    int               exp_frames   = 0;
    int               beat_cyc     = 0;
    logic             exp_err      = 1'b0;
    logic [WIDTH-1:0] stim [DEPTH];
    logic [WIDTH-1:0] expect_q [$];

    sort_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef SORT_STREAM_BYPASS_EN
        .bypass     (1'b0),
`endif
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_dir     (in_dir),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .frame_err  (frame_err),
        .frames_done(frames_done)
    );

    // Free-running clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Hard stop if something hangs beyond all per-wait bounds.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: the output of a frame is its values sorted in the requested order.
    function automatic void buildExpected(input int n, input bit asc);
        logic [WIDTH-1:0] a [DEPTH];
        logic [WIDTH-1:0] t;
        expect_q.delete();
        for (int i = 0; i < n; i++) a[i] = stim[i];
        for (int i = 0; i < n; i++) begin
            for (int j = i + 1; j < n; j++) begin
                if (asc ? (a[j] < a[i]) : (a[j] > a[i])) begin
                    t = a[i]; a[i] = a[j]; a[j] = t;
                end
            end
        end
        for (int i = 0; i < n; i++) expect_q.push_back(a[i]);
    endfunction

    task automatic doReset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        in_dir = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_frames = 0;
        exp_err    = 1'b0;
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_out_last", out_last, 0);
        checkOutput("rst_frame_err", frame_err, 0);
        checkOutput("rst_frames_done", frames_done, 0);
    endtask

    // Drive one frame with random idle gaps; direction is only valid on beat 0.
    task automatic applyStimulus(input int n, input bit asc, input bit use_last);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = stim[i];
            in_last  = use_last && (i == n - 1);
            in_dir   = (i == 0) ? asc : ~asc;
            checkOutput("in_ready_load", in_ready, 1);
            beat_cyc = cyc;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!use_last) exp_err = 1'b1;
    endtask

    // Wait for the sorted frame and drain it under random backpressure.
    task automatic collectOutput(input int n);
        int guard = 0;
        int k = 0;
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        in_last  = 1'b1;
        checkOutput("in_ready_sort", in_ready, 0);
        while (!out_valid && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!out_valid) begin
            checkOutput("first_valid_timeout", 0, 1);
            return;
        end
        checkOutput("latency", cyc - beat_cyc, DEPTH + 1);
        guard = 0;
        while (k < n && guard < 200) begin
            checkOutput("out_valid_drain", out_valid, 1);
            checkOutput($sformatf("data[%0d]", k), out_data, expect_q[k]);
            checkOutput($sformatf("last[%0d]", k), out_last, (k == n - 1) ? 1 : 0);
            out_ready = ($urandom_range(0, 2) != 0);
            if (out_ready) k++;
            @(posedge clk); #1;
            guard++;
        end
        out_ready = 1'b0;
        if (k < n) checkOutput("drain_timeout", k, n);
        exp_frames++;
        checkOutput("out_valid_after", out_valid, 0);
        checkOutput("frames_done", frames_done, exp_frames);
        checkOutput("frame_err", frame_err, exp_err);
    endtask

    task automatic runFrame(input int n, input bit asc, input bit use_last);
        buildExpected(n, asc);
        applyStimulus(n, asc, use_last);
        collectOutput(n);
    endtask

    initial begin
        int n;
        bit asc;
        bit use_last;

        doReset();

        // Full ascending frame.
        stim[0] = 5; stim[1] = 3; stim[2] = 9; stim[3] = 1;
        stim[4] = 7; stim[5] = 2; stim[6] = 8; stim[7] = 4;
        runFrame(8, 1'b1, 1'b1);

        // Short descending frame.
        stim[0] = 5; stim[1] = 3; stim[2] = 9; stim[3] = 1;
        runFrame(4, 1'b0, 1'b1);

        // Real values equal to the ascending sentinel.
        stim[0] = 32'hFFFF_FFFF; stim[1] = 2; stim[2] = 32'hFFFF_FFFF;
        runFrame(3, 1'b1, 1'b1);

        // Descending frame containing zeros (the descending sentinel).
        stim[0] = 0; stim[1] = 6; stim[2] = 0;
        runFrame(3, 1'b0, 1'b1);

        // Single-element frame.
        stim[0] = 32'h1234_5678;
        runFrame(1, 1'b1, 1'b1);

        // Overlong frame: closes at DEPTH beats and sets the sticky error.
        for (int i = 0; i < DEPTH; i++) stim[i] = 32'(DEPTH - i) * 3;
        runFrame(DEPTH, 1'b1, 1'b0);

        // Following frame proceeds normally with the error still held.
        stim[0] = 10; stim[1] = 20;
        runFrame(2, 1'b0, 1'b1);

        // Randomized frames, including duplicates and extreme values.
        for (int f = 0; f < 20; f++) begin
            n        = $urandom_range(1, DEPTH);
            asc      = bit'($urandom_range(0, 1));
            use_last = (n < DEPTH) || ($urandom_range(0, 1) == 1);
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 4))
                    0:       stim[i] = 32'hFFFF_FFFF;
                    1:       stim[i] = 0;
                    2:       stim[i] = 32'($urandom_range(0, 3));
                    default: stim[i] = $urandom;
                endcase
            end
            runFrame(n, asc, use_last);
        end

        // Reset in the middle of sorting discards the frame and clears status.
        stim[0] = 7; stim[1] = 3;
        applyStimulus(2, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_frames = 0;
        exp_err    = 1'b0;
        checkOutput("midsort_out_valid", out_valid, 0);
        checkOutput("midsort_out_data", out_data, 0);
        checkOutput("midsort_out_last", out_last, 0);
        checkOutput("midsort_frame_err", frame_err, 0);
        checkOutput("midsort_frames_done", frames_done, 0);
        checkOutput("midsort_in_ready", in_ready, 1);
        stim[0] = 4; stim[1] = 1;
        runFrame(2, 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
